// File: rtl/alu_arbiter_if.sv
// Request, response and shared-ALU signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/ALU side.
interface alu_arbiter_if;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [63:0] req_data1_i;
    logic [63:0] req_data2_i;
    logic [5:0]  req_ctrl_i;
    logic [1:0]  resp_valid_o;
    logic [1:0]  resp_ready_i;
    logic [31:0] resp_data_o;
    logic        resp_zero_o;
    logic [31:0] alu_data1_o;
    logic [31:0] alu_data2_o;
    logic [2:0]  alu_ctrl_o;
    logic [31:0] alu_data_i;

    modport slave (
        input  req_valid_i, req_data1_i, req_data2_i, req_ctrl_i, resp_ready_i, alu_data_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_zero_o,
               alu_data1_o, alu_data2_o, alu_ctrl_o
    );

    modport master (
        output req_valid_i, req_data1_i, req_data2_i, req_ctrl_i, resp_ready_i, alu_data_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_zero_o,
               alu_data1_o, alu_data2_o, alu_ctrl_o
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared multi-cycle ALU.
// ALU_ARBITER_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    alu_arbiter_if.slave bus,
    output logic         busy_o
);
    localparam logic [2:0] CTRL_MUL  = 3'b101;
    localparam bit         MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [3:0] MUL_LOAD  = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic [1:0]  grant;
    logic [1:0]  ready;

    logic [31:0] data1_arr [2];
    logic [31:0] data2_arr [2];
    logic [2:0]  ctrl_arr  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign data1_arr[gi] = bus.req_data1_i[32*gi +: 32];
            assign data2_arr[gi] = bus.req_data2_i[32*gi +: 32];
            assign ctrl_arr[gi]  = bus.req_ctrl_i[3*gi +: 3];
        end
    endgenerate

    // A single valid requester always wins; only contention consults the policy.
    always_comb begin
        grant = bus.req_valid_i;
        if (bus.req_valid_i == 2'b11) begin
`ifdef ALU_ARBITER_RR_EN
            grant = last_q ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        ctrl_d  = ctrl_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        ready   = 2'b00;
        case (state_q)
            IDLE: begin
                if (rst_n_i) begin
                    ready = grant;
                end
                if (grant != 2'b00) begin
                    op1_d   = data1_arr[grant[1]];
                    op2_d   = data2_arr[grant[1]];
                    ctrl_d  = ctrl_arr[grant[1]];
                    owner_d = grant[1];
                    last_d  = grant[1];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ctrl_q == CTRL_MUL && MUL_MULTI) begin
                    cnt_d   = MUL_LOAD;
                    state_d = WAIT;
                end else begin
                    res_d   = bus.alu_data_i;
                    zero_d  = (bus.alu_data_i == 32'd0);
                    state_d = RESP;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_d   = bus.alu_data_i;
                    zero_d  = (bus.alu_data_i == 32'd0);
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            op1_q   <= 32'd0;
            op2_q   <= 32'd0;
            ctrl_q  <= 3'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            res_q   <= 32'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            ctrl_q  <= ctrl_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.resp_valid_o = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_data_o  = res_q;
    assign bus.resp_zero_o  = zero_q;
    assign bus.alu_data1_o  = op1_q;
    assign bus.alu_data2_o  = op2_q;
    assign bus.alu_ctrl_o   = ctrl_q;
    assign busy_o           = (state_q != IDLE);
endmodule
